alu: RTL and testbench

ALU -- requirements
Module: ALU

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 44 ++++
 rtl/alu.sv | 34 +++
 tb/tb_alu.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width, opcode encoding and decode helper
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  // SUB and SLT both drive the shared adder in A + ~B + 1 mode
  function automatic logic uses_subtract(input alu_op_e op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath with one shared adder
module alu_core #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] result
);
  import alu_pkg::*;

  alu_op_e            op;
  logic               sub;
  logic [WIDTH-1:0]   b_opnd;
  logic [WIDTH-1:0]   sum;
  logic               slt;
  logic [SHAMT_W-1:0] shamt;

  assign op     = alu_op_e'(ALUControl);
  assign sub    = uses_subtract(op);
  // Subtraction reuses the adder: invert B and inject the +1 as carry-in
  assign b_opnd = sub ? ~SrcB : SrcB;
  assign sum    = SrcA + b_opnd + WIDTH'(sub);
  // When the signs differ the difference may overflow, so A's sign alone decides
  assign slt    = (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]) ? SrcA[WIDTH-1] : sum[WIDTH-1];
  assign shamt  = SrcB[SHAMT_W-1:0];

  // Operation select; every code defined so the output is never X
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = sum;
      ALU_SUB: result = sum;
      ALU_AND: result = SrcA & SrcB;
      ALU_OR:  result = SrcA | SrcB;
      ALU_XOR: result = SrcA ^ SrcB;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt};
      ALU_SLL: result = SrcA << shamt;
      ALU_SRL: result = SrcA >> shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - ALU top: combinational core plus registered result and zero flag
module alu #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  logic [WIDTH-1:0] result;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .result     (result)
  );

  // Capture result and its zero flag together every cycle; reset clears immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUResult <= '0;
      Zero      <= 1'b1;
    end else begin
      ALUResult <= result;
      Zero      <= (result == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for the registered ALU
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    string       nm;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  ALUControl;
  logic [31:0] ALUResult;
  logic        Zero;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drive one operation and record what must appear after the next rising edge
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] er, input logic ez, input string nm);
    exp_t e;
    SrcA       = a;
    SrcB       = b;
    ALUControl = op;
    e.res  = er;
    e.zero = ez;
    e.nm   = nm;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [31:0] er, input logic ez, input string nm);
    @(negedge clk);
    drive(a, b, op, er, ez, nm);
  endtask

  // Monitor: one captured result per rising edge while out of reset
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.nm, " result"}, ALUResult, e.res);
        check({e.nm, " zero"}, {31'b0, Zero}, {31'b0, e.zero});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    SrcA       = 32'd20000;
    SrcB       = 32'd10000;
    ALUControl = ALU_ADD;
    #2;
    check("reset before first edge result", ALUResult, 32'h0);
    check("reset before first edge zero", {31'b0, Zero}, 32'h1);
    @(posedge clk);
    #1;
    check("reset held result", ALUResult, 32'h0);
    check("reset held zero", {31'b0, Zero}, 32'h1);

    // First capture happens on the first edge after release
    @(negedge clk);
    reset = 1'b0;
    drive(32'd20000, 32'd10000, ALU_ADD, 32'd30000, 1'b0, "add 20000+10000");
    step(32'd20000, 32'd10000, ALU_SUB, 32'd10000, 1'b0, "sub 20000-10000");
    step(32'd20000, 32'd10000, ALU_AND, 32'd1536,  1'b0, "and");
    step(32'd20000, 32'd10000, ALU_OR,  32'd28464, 1'b0, "or");
    step(32'd20000, 32'd10000, ALU_XOR, 32'd26928, 1'b0, "xor");
    step(32'd20000, 32'd10000, ALU_SLT, 32'd0,     1'b1, "slt 20000<10000");
    step(32'd20000, 32'd20000, ALU_SUB, 32'd0,     1'b1, "sub equal");
    step(32'h0000_0000, 32'h0000_0001, ALU_SUB, 32'hFFFF_FFFF, 1'b0, "sub wrap 0-1");
    step(32'hFFFF_FFFF, 32'h0000_0001, ALU_SLT, 32'h1, 1'b0, "slt -1<1");
    step(32'h7FFF_FFFF, 32'h8000_0000, ALU_SLT, 32'h0, 1'b1, "slt max<min");
    step(32'h8000_0000, 32'h0000_0001, ALU_SLT, 32'h1, 1'b0, "slt min<1 overflow");
    step(32'hFFFF_FFFF, 32'h0000_0001, ALU_ADD, 32'h0, 1'b1, "add wrap");
    step(32'h0000_0001, 32'h0000_003F, ALU_SLL, 32'h8000_0000, 1'b0, "sll by 63 uses 31");
    step(32'h0000_0003, 32'h0000_0020, ALU_SLL, 32'h0000_0003, 1'b0, "sll by 32 uses 0");
    step(32'h8000_0000, 32'd31,        ALU_SRL, 32'h1, 1'b0, "srl by 31");
    step(32'hF000_0000, 32'h0000_0024, ALU_SRL, 32'h0F00_0000, 1'b0, "srl ignores high b");
    step(32'h1234_5678, 32'h1234_5678, ALU_XOR, 32'h0, 1'b1, "xor equal");
    step(32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0, "add before async reset");

    // Async reset between edges clears the held result at once
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async reset result", ALUResult, 32'h0);
    check("async reset zero", {31'b0, Zero}, 32'h1);
    @(negedge clk);
    SrcA       = 32'd100;
    SrcB       = 32'd1;
    ALUControl = ALU_SUB;
    @(posedge clk);
    #1;
    check("pending op discarded result", ALUResult, 32'h0);
    check("pending op discarded zero", {31'b0, Zero}, 32'h1);

    @(negedge clk);
    reset = 1'b0;
    drive(32'h0000_00F0, 32'h0000_000F, ALU_OR, 32'h0000_00FF, 1'b0, "or after reset");
    step(32'hFFFF_0000, 32'h0F0F_0F0F, ALU_AND, 32'h0F0F_0000, 1'b0, "and after reset");
    step(32'd9, 32'd9, ALU_SUB, 32'd0, 1'b1, "sub equal after reset");

    @(negedge clk);
    @(posedge clk);
    #2;
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
